// File: rtl/gate_selftest_pkg.sv
// Shared constants for the gate self-test block: FSM encoding, gate_in bit positions
// and the legal SETTLE_CYCLES range.
package gate_selftest_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        DRIVE  = ST_DRIVE,
        SAMPLE = ST_SAMPLE,
        DONE   = ST_DONE
    } state_e;

    localparam int GATE_W    = 7;
    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOT  = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;

    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/gate_selftest_expect.sv
// gate_expect: golden response of the seven-gate stage for one operand pair.
module gate_expect
    import gate_selftest_pkg::*;
(
    input  logic              a_i,
    input  logic              b_i,
    output logic [GATE_W-1:0] exp_o
);

    always_comb begin
        exp_o            = '0;
        exp_o[GATE_AND]  = a_i & b_i;
        exp_o[GATE_OR]   = a_i | b_i;
        exp_o[GATE_NOT]  = ~a_i;
        exp_o[GATE_NAND] = ~(a_i & b_i);
        exp_o[GATE_NOR]  = ~(a_i | b_i);
        exp_o[GATE_XOR]  = a_i ^ b_i;
        exp_o[GATE_XNOR] = ~(a_i ^ b_i);
    end

endmodule

// File: rtl/gate_selftest.sv
// Walks operands 00..11 through an external gate stage and counts failing vectors.
// Optional first-failure log enabled by defining GATE_SELFTEST_FAILLOG_EN.
module gate_selftest
    import gate_selftest_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [GATE_W-1:0] gate_in,
    output logic              a_out,
    output logic              b_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              pass_out,
    output logic [2:0]        err_cnt_out
`ifdef GATE_SELFTEST_FAILLOG_EN
    ,
    output logic [1:0]        fail_vec_out,
    output logic [GATE_W-1:0] fail_mask_out
`endif
);

    if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
        $error("gate_selftest: SETTLE_CYCLES out of range 1..15");
    end

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        err_q, err_d;
    logic              pass_q, pass_d;
    logic [2:0]        res_err_q, res_err_d;
    logic [GATE_W-1:0] exp_gate;
    logic [GATE_W-1:0] mismatch;
    logic              vec_fail;
    logic              busy;

    gate_expect u_expect (
        .a_i   (idx_q[1]),
        .b_i   (idx_q[0]),
        .exp_o (exp_gate)
    );

    assign mismatch = gate_in ^ exp_gate;
    assign vec_fail = |mismatch;
    assign busy     = (state_q == DRIVE) || (state_q == SAMPLE);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        pass_d    = pass_q;
        res_err_d = res_err_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = DRIVE;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    err_d   = 3'd0;
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                err_d = err_q + {2'b00, vec_fail};
                if (idx_q == 2'd3) begin
                    // Results land together with the DONE pulse, including this last vector.
                    state_d   = DONE;
                    pass_d    = (err_q == 3'd0) && !vec_fail;
                    res_err_d = err_q + {2'b00, vec_fail};
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= 4'd0;
            err_q     <= 3'd0;
            pass_q    <= 1'b0;
            res_err_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            res_err_q <= res_err_d;
        end
    end

    assign a_out       = busy & idx_q[1];
    assign b_out       = busy & idx_q[0];
    assign busy_out    = busy;
    assign done_out    = (state_q == DONE);
    assign pass_out    = pass_q;
    assign err_cnt_out = res_err_q;

`ifdef GATE_SELFTEST_FAILLOG_EN
    logic [1:0]        fvec_q, fvec_d;
    logic [GATE_W-1:0] fmask_q, fmask_d;

    // A failing vector always has a non-zero mask, so an empty mask means "nothing logged yet".
    always_comb begin
        fvec_d  = fvec_q;
        fmask_d = fmask_q;
        if (state_q == IDLE && start_in) begin
            fvec_d  = 2'd0;
            fmask_d = '0;
        end else if (state_q == SAMPLE && vec_fail && fmask_q == '0) begin
            fvec_d  = idx_q;
            fmask_d = mismatch;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fvec_q  <= 2'd0;
            fmask_q <= '0;
        end else begin
            fvec_q  <= fvec_d;
            fmask_q <= fmask_d;
        end
    end

    assign fail_vec_out  = fvec_q;
    assign fail_mask_out = fmask_q;
`endif

endmodule

// File: tb/tb_gate_selftest.sv
// Scoreboard bench for gate_selftest: driver pushes expected pass results, monitors pop on done_out.
module tb_gate_selftest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst, start, start1, start15;
    logic [6:0] stuck0, invm;
    logic [6:0] gate, gate1, gate15;
    logic       a, b, busy, done, pass;
    logic [2:0] err;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic       a15, b15, busy15, done15, pass15;
    logic [2:0] err15;
`ifdef GATE_SELFTEST_FAILLOG_EN
    logic [1:0] fvec, fvec1, fvec15;
    logic [6:0] fmask, fmask1, fmask15;
`endif

    // Fault-free gate stage, bit order {xnor,xor,nor,nand,not,or,and}
    function automatic logic [6:0] gates(input logic x, input logic y);
        return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~x, x | y, x & y};
    endfunction

    assign gate   = (gates(a, b) & ~stuck0) ^ invm;
    assign gate1  = gates(a1, b1);
    assign gate15 = gates(a15, b15);

    gate_selftest #(.SETTLE_CYCLES(2)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .gate_in(gate),
        .a_out(a), .b_out(b), .busy_out(busy), .done_out(done),
        .pass_out(pass), .err_cnt_out(err)
`ifdef GATE_SELFTEST_FAILLOG_EN
        , .fail_vec_out(fvec), .fail_mask_out(fmask)
`endif
    );

    gate_selftest #(.SETTLE_CYCLES(1)) dut1 (
        .clk_in(clk), .rst_in(rst), .start_in(start1), .gate_in(gate1),
        .a_out(a1), .b_out(b1), .busy_out(busy1), .done_out(done1),
        .pass_out(pass1), .err_cnt_out(err1)
`ifdef GATE_SELFTEST_FAILLOG_EN
        , .fail_vec_out(fvec1), .fail_mask_out(fmask1)
`endif
    );

    gate_selftest #(.SETTLE_CYCLES(15)) dut15 (
        .clk_in(clk), .rst_in(rst), .start_in(start15), .gate_in(gate15),
        .a_out(a15), .b_out(b15), .busy_out(busy15), .done_out(done15),
        .pass_out(pass15), .err_cnt_out(err15)
`ifdef GATE_SELFTEST_FAILLOG_EN
        , .fail_vec_out(fvec15), .fail_mask_out(fmask15)
`endif
    );

    typedef struct {
        int         lat;
        logic       pass;
        logic [2:0] err;
        logic [1:0] fvec;
        logic [6:0] fmask;
        int         busy;
        logic [7:0] seq;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q1[$];
    int   lat_q15[$];
    int   st_cyc, st_cyc1, st_cyc15;
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_exp(input logic p, input logic [2:0] e, input logic [1:0] fv,
                            input logic [6:0] fm);
        exp_t x;
        x.lat   = 13;
        x.pass  = p;
        x.err   = e;
        x.fvec  = fv;
        x.fmask = fm;
        x.busy  = 12;
        x.seq   = 8'h1B;
        exp_q.push_back(x);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start  = 1'b1;
        st_cyc = cyc;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_all(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() + lat_q1.size() + lat_q15.size()) != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("queues_drained", exp_q.size() + lat_q1.size() + lat_q15.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, a, 0);
        check({tag, "_b"}, b, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err, 0);
`ifdef GATE_SELFTEST_FAILLOG_EN
        check({tag, "_fvec"}, fvec, 0);
        check({tag, "_fmask"}, fmask, 0);
`endif
    endtask

    // Main monitor: tracks a/b sequence and busy length, scores each done pulse
    initial begin
        int         busy_cnt;
        logic [7:0] seq;
        logic [1:0] last_ab;
        logic       prev_done;
        exp_t       e;
        busy_cnt  = 0;
        seq       = 8'h00;
        last_ab   = 2'b00;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                if (busy_cnt == 0 || {a, b} != last_ab) seq = {seq[5:0], a, b};
                last_ab = {a, b};
                busy_cnt++;
            end
            if (done) begin
                if (prev_done) begin
                    check("done_pulse_width", 2, 1);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_latency", cyc - st_cyc, e.lat);
                    check("pass_out", pass, e.pass);
                    check("err_cnt_out", err, e.err);
                    check("busy_cycles", busy_cnt, e.busy);
                    check("ab_sequence", seq, e.seq);
                    check("ab_in_done", {a, b}, 0);
`ifdef GATE_SELFTEST_FAILLOG_EN
                    check("fail_vec_out", fvec, e.fvec);
                    check("fail_mask_out", fmask, e.fmask);
`endif
                end
            end
            if (!busy && !done) begin
                busy_cnt = 0;
                seq      = 8'h00;
            end
            prev_done = done;
        end
    end

    initial begin
        int l;
        forever begin
            @(negedge clk);
            if (done1) begin
                if (lat_q1.size() == 0) check("s1_unexpected_done", 1, 0);
                else begin
                    l = lat_q1.pop_front();
                    check("s1_latency", cyc - st_cyc1, l);
                    check("s1_pass", pass1, 1);
                end
            end
        end
    end

    initial begin
        int l;
        forever begin
            @(negedge clk);
            if (done15) begin
                if (lat_q15.size() == 0) check("s15_unexpected_done", 1, 0);
                else begin
                    l = lat_q15.pop_front();
                    check("s15_latency", cyc - st_cyc15, l);
                    check("s15_pass", pass15, 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0; start15 = 1'b0;
        stuck0 = 7'h00; invm = 7'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Fault-free pass on all three instances; S=1 and S=15 give 9 and 65 cycle latency
        push_exp(1'b1, 3'd0, 2'd0, 7'h00);
        lat_q1.push_back(9);
        lat_q15.push_back(65);
        @(negedge clk);
        start = 1'b1; start1 = 1'b1; start15 = 1'b1;
        st_cyc = cyc; st_cyc1 = cyc; st_cyc15 = cyc;
        @(negedge clk);
        start = 1'b0; start1 = 1'b0; start15 = 1'b0;
        wait_all(200);

        // AND output stuck at 0: only vector 11 fails
        stuck0 = 7'b0000001;
        push_exp(1'b0, 3'd1, 2'd3, 7'b0000001);
        pulse_start();
        wait_all(100);
        stuck0 = 7'h00;

        // XOR output inverted: every vector fails, first at 00
        invm = 7'b0100000;
        push_exp(1'b0, 3'd4, 2'd0, 7'b0100000);
        pulse_start();
        wait_all(100);
        invm = 7'h00;

        // start re-pulsed at cycles 3 and 8, and again during the DONE cycle
        push_exp(1'b1, 3'd0, 2'd0, 7'h00);
        pulse_start();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_in_done_ignored", busy, 0);
        wait_all(50);

        // Reset while vector 10 is driven: abort, outputs cleared, no done pulse
        pulse_start();
        repeat (7) @(negedge clk);
        check("ab_vector2", {a, b}, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("abort");
        repeat (20) @(negedge clk);
        check("abort_idle_busy", busy, 0);

        push_exp(1'b1, 3'd0, 2'd0, 7'h00);
        pulse_start();
        wait_all(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/gate_selftest.md
GATE_SELFTEST -- requirements
Module: gate_selftest

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles the stimulus is held before sampling; legal range 1..15.
REQ-002 SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_in  input  1  single-cycle request to run one self-test pass.
REQ-005 SHALL have port gate_in  input  7  gate results under test, bit order {xnor,xor,nor,nand,not,or,and} (bit 0 = and).
REQ-006 SHALL have port a_out  output  1  stimulus operand A to the gate stage.
REQ-007 SHALL have port b_out  output  1  stimulus operand B to the gate stage.
REQ-008 SHALL have port busy_out  output  1  high while a pass is in progress.
REQ-009 SHALL have port done_out  output  1  one-cycle pulse at the end of a pass.
REQ-010 SHALL have port pass_out  output  1  result of the last completed pass (1 = no mismatches).
REQ-011 SHALL have port err_cnt_out  output  3  number of failing vectors in the last pass, 0..4.

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-013 SHALL leave IDLE for DRIVE when start_in=1, clearing the error count and setting the vector index to 0.
REQ-014 SHALL drive {a_out,b_out} = vector index (00, 01, 10, 11 in order) during DRIVE and SAMPLE; 0 in IDLE and DONE.
REQ-015 SHALL stay in DRIVE exactly SETTLE_CYCLES cycles, then spend exactly one SAMPLE cycle per vector.
REQ-016 SHALL compare gate_in in SAMPLE against expected {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b}; any mismatching bit counts the vector as failing (err_cnt +1).
REQ-017 SHALL go from SAMPLE to DRIVE with index+1 if index<3, else to DONE.
REQ-018 SHALL pulse done_out for the single DONE cycle, then return to IDLE.
REQ-019 SHALL update pass_out and err_cnt_out in the DONE cycle and hold them until the next DONE or reset.
REQ-020 SHALL assert done_out exactly 4*(SETTLE_CYCLES+1)+1 cycles after the cycle start_in is sampled (13 for default).
REQ-021 SHALL assert busy_out in DRIVE and SAMPLE only.
REQ-022 SHALL ignore start_in outside IDLE, including in the DONE cycle.

Reset
REQ-023 SHALL, with rst_in=1, force state IDLE and a_out, b_out, busy_out, done_out, pass_out, err_cnt_out to 0 on the next edge.
REQ-024 SHALL, on reset mid-pass, abort without a done_out pulse; results are 0 until the next completed pass.

Configuration
REQ-025 SHALL, with macro GATE_SELFTEST_FAILLOG_EN defined, add outputs fail_vec_out (2 bits) and fail_mask_out (7 bits), with bit order as gate_in.
REQ-026 SHALL make these outputs record the index and XOR mismatch mask of the first failing vector of a pass; both are cleared on start and reset and are held after DONE.
REQ-027 SHALL, without GATE_SELFTEST_FAILLOG_EN, omit those ports and the logic behind them; all other behaviour is identical.

Structure
REQ-028 SHALL place the state enum, gate_in bit-index constants and the SETTLE_CYCLES legal limits in package gate_selftest_pkg.
REQ-029 SHALL compute expected values in one combinational sub-module, gate_expect (a, b -> 7-bit expected).

Verification
REQ-030 SHALL test a fault-free gate stage connected, SETTLE_CYCLES=2, start pulse -> a/b sequence 00,01,10,11; done_out 13 cycles later; pass_out=1; err_cnt_out=0.
REQ-031 SHALL test gate_in bit 0 stuck at 0 -> err_cnt_out=1, pass_out=0; FAILLOG: fail_vec_out=3, fail_mask_out=7'b0000001.
REQ-032 SHALL test gate_in bit 5 (xor) inverted -> err_cnt_out=4, pass_out=0; FAILLOG: fail_vec_out=0, fail_mask_out=7'b0100000.
REQ-033 SHALL test start_in re-pulsed at cycles 3 and 8 of a pass -> no restart; done_out still at cycle 13; single pulse.
REQ-034 SHALL test rst_in during vector 2 -> all outputs 0 next cycle, no done_out; a following start gives a full pass with pass_out=1.
REQ-035 SHALL test SETTLE_CYCLES=1 and 15 -> done_out latency 9 and 65 cycles respectively.
